// File: rtl/ripple_add_4bit_behavioral.sv
`default_nettype none
// ============================================================================
// Module     : ripple_add_4bit_behavioral
// Description: Registered 4-bit ripple-carry adder with carry in and carry out.
// Revision   : 1.0 - initial release
// ============================================================================
module ripple_add_4bit_behavioral (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);

  localparam int c_WIDTH = 4;

  logic [c_WIDTH:0]   w_carry;
  logic [c_WIDTH-1:0] w_sum;
  logic [3:1]         w_carry_int;
  logic               w_carry_final;

  assign w_carry[0] = carry_in;

  // One behavioural full adder per bit; carries ripple from bit 0 upward.
  generate
    for (genvar i = 0; i < c_WIDTH; i++) begin : g_stage
      assign w_sum[i]       = a[i] ^ b[i] ^ w_carry[i];
      assign w_carry[i + 1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
    end
  endgenerate

  assign w_carry_int   = w_carry[3:1];
  assign w_carry_final = w_carry[c_WIDTH];

  logic [3:0] r_sum;
  logic       r_carry_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= 4'b0000;
      r_carry_out <= 1'b0;
    end else begin
      r_sum       <= w_sum;
      r_carry_out <= w_carry_final;
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_carry_out;

  // The intermediate carries are kept visible for debug but drive nothing.
  logic w_unused;
  assign w_unused = ^w_carry_int;

endmodule
`default_nettype wire

// File: tb/tb_ripple_add_4bit_behavioral.sv
`default_nettype none
// ============================================================================
// Module     : tb_ripple_add_4bit_behavioral
// Description: Directed and exhaustive self-checking bench for the 4-bit adder.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_ripple_add_4bit_behavioral;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       carry_in;
  logic [3:0] sum;
  logic       carry_out;

  int checks;
  int failures;

  ripple_add_4bit_behavioral dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_result(input string tag, input logic [4:0] observed, input logic [4:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got {carry_out,sum}=%b, expected %b", tag, observed, expected);
    end
  endtask

  // Drive operands, clock once, sample just after the edge.
  task automatic apply(input logic [3:0] va, input logic [3:0] vb, input logic vc);
    a        = va;
    b        = vb;
    carry_in = vc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    a        = 4'd0;
    b        = 4'd0;
    carry_in = 1'b0;

    // Make outputs nonzero, then reset asynchronously between edges.
    apply(4'hF, 4'hF, 1'b1);
    check_result("preload", {carry_out, sum}, 5'b1_1111);
    #2;
    rst_n = 1'b0;
    #1;
    check_result("async_reset", {carry_out, sum}, 5'b0_0000);
    @(posedge clk);
    #1;
    check_result("reset_hold", {carry_out, sum}, 5'b0_0000);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    apply(4'b0000, 4'b0000, 1'b0);
    check_result("release_zero", {carry_out, sum}, 5'b0_0000);

    // Small values, mid-range and carry chain.
    apply(4'b0000, 4'b0000, 1'b1);
    check_result("0+0+1", {carry_out, sum}, 5'b0_0001);
    apply(4'b0001, 4'b0001, 1'b0);
    check_result("1+1+0", {carry_out, sum}, 5'b0_0010);
    apply(4'b0001, 4'b0001, 1'b1);
    check_result("1+1+1", {carry_out, sum}, 5'b0_0011);
    apply(4'd3, 4'd6, 1'b0);
    check_result("3+6+0", {carry_out, sum}, 5'b0_1001);
    apply(4'b1111, 4'b0000, 1'b1);
    check_result("wrap", {carry_out, sum}, 5'b1_0000);
    apply(4'b1111, 4'b1111, 1'b1);
    check_result("max", {carry_out, sum}, 5'b1_1111);
    apply(4'b1000, 4'b1000, 1'b0);
    check_result("msb_carry", {carry_out, sum}, 5'b1_0000);
    apply(4'b1010, 4'b0101, 1'b1);
    check_result("full_propagate", {carry_out, sum}, 5'b1_0000);
    apply(4'b0101, 4'b0010, 1'b0);
    check_result("b2b_1", {carry_out, sum}, 5'b0_0111);
    apply(4'b1100, 4'b0110, 1'b1);
    check_result("b2b_2", {carry_out, sum}, 5'b1_0011);

    // Reset pulse mid-stream: outputs drop at once, next edge loads current inputs.
    a        = 4'd9;
    b        = 4'd4;
    carry_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_result("mid_reset", {carry_out, sum}, 5'b0_0000);
    #1;
    rst_n = 1'b1;
    #1;
    check_result("mid_reset_hold", {carry_out, sum}, 5'b0_0000);
    @(posedge clk);
    #1;
    check_result("mid_reset_reload", {carry_out, sum}, 5'b0_1110);

    // Exhaustive sweep against plain integer addition.
    for (int i = 0; i < 512; i++) begin
      logic [3:0] ea;
      logic [3:0] eb;
      logic       ec;
      logic [4:0] exp_val;
      ea      = i[3:0];
      eb      = i[7:4];
      ec      = i[8];
      exp_val = {1'b0, ea} + {1'b0, eb} + {4'b0000, ec};
      apply(ea, eb, ec);
      check_result($sformatf("exh_%0d", i), {carry_out, sum}, exp_val);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
